fpro_uart_tx_core: RTL and testbench

Memory-mapped UART transmitter core that occupies one slot of the MMIO subsystem, downstream of the FPro bridge. The MicroBlaze writes bytes into an 8-entry TX FIFO over the slot bus, and the core serialises them as 8N1 frames on `tx` at a programmable bit period. Status is readable through the same slot for software polling.

---
 rtl/fpro_uart_pkg.sv | 16 +
 rtl/fpro_uart_tx_core_fifo_sync.sv | 51 +++++
 rtl/fpro_uart_tx_core.sv | 177 +++++++++++++++++
 tb/tb_fpro_uart_tx_core.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fpro_uart_pkg.sv
// Shared register map, STATUS layout and FSM state type for the FPro UART TX core.
package fpro_uart_pkg;

    localparam logic [4:0] REG_STATUS = 5'd0;
    localparam logic [4:0] REG_DVSR   = 5'd1;
    localparam logic [4:0] REG_TXDATA = 5'd2;
    localparam logic [4:0] REG_CLR    = 5'd3;

    localparam int ST_FULL  = 4;
    localparam int ST_EMPTY = 5;
    localparam int ST_BUSY  = 6;
    localparam int ST_OVF   = 7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/fpro_uart_tx_core_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; pushes while full and pops while empty are ignored.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rptr_q];
    // Full/empty are the pre-update flags, so a push while full is dropped even if a pop lands this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fpro_uart_tx_core.sv
// MMIO UART transmitter: register decode, TX FIFO, per-frame bit timer and 8N1 framing FSM.
module fpro_uart_tx_core
    import fpro_uart_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DVSR_RST   = 16'd10415
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    logic                  wr_en, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW-1:0]         fifo_cnt;

    logic [15:0]           dvsr_q, dvsr_d;
    logic                  ovf_q, ovf_d;
    tx_state_t             state_q, state_d;
    logic [15:0]           tick_q, tick_d;
    logic [15:0]           fdvsr_q, fdvsr_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  bit_done;
    logic [31:0]           status;
    logic                  unused_bits;

    assign unused_bits = ^{read, wr_data[31:16]};

    assign wr_en     = cs & write;
    assign fifo_push = wr_en && (addr == REG_TXDATA);

    fifo_sync #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data[DATA_WIDTH-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        dvsr_d = dvsr_q;
        ovf_d  = ovf_q;
        if (wr_en && addr == REG_DVSR) dvsr_d = wr_data[15:0];
        if (wr_en && addr == REG_CLR)  ovf_d  = 1'b0;
        if (fifo_push && fifo_full)    ovf_d  = 1'b1;
    end

    always_comb begin
        status           = '0;
        status[3:0]      = 4'(fifo_cnt);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = (state_q != IDLE);
        status[ST_OVF]   = ovf_q;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_STATUS: rd_data = status;
            REG_DVSR:   rd_data = {16'h0000, dvsr_q};
            default:    rd_data = '0;
        endcase
    end

    // Bit period comes from the divisor latched at pop, so DVSR writes never disturb a frame in flight.
    assign bit_done = (tick_q == fdvsr_q);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        fdvsr_d   = fdvsr_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    fdvsr_d  = dvsr_q;
                    tick_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    tick_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    tick_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        fdvsr_d  = dvsr_q;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line trails the FSM by one clock.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_q    <= DVSR_RST;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            tick_q    <= '0;
            fdvsr_q   <= DVSR_RST;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            dvsr_q    <= dvsr_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            fdvsr_q   <= fdvsr_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_fpro_uart_tx_core.sv
// Directed bench for fpro_uart_tx_core: expected tx levels are queued per clock and popped by a monitor.
module tb_fpro_uart_tx_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        tx;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  tx_idx   = 0;
    bit  exp_q[$];

    fpro_uart_tx_core dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One expected tx level per clock, consumed just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            chk($sformatf("tx[%0d]", tx_idx), {31'b0, tx}, {31'b0, e});
            tx_idx++;
        end
    end

    task automatic exp_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    task automatic exp_frame(input logic [7:0] b, input int dv);
        repeat (dv + 1) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (dv + 1) exp_q.push_back(b[i]);
        repeat (dv + 1) exp_q.push_back(1'b1);
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] e);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        chk(tag, rd_data, e);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("reset_tx", {31'b0, tx}, 32'd1);
        reset = 1'b0;
        rd_chk("reset_status", 5'd0, 32'h0000_0020);
        rd_chk("reset_dvsr",   5'd1, 32'd10415);
        rd_chk("rd_txdata_0",  5'd2, 32'h0);
        rd_chk("rd_unmapped",  5'd9, 32'h0);

        // Single byte 0xA5, DVSR=3
        wr(5'd1, 32'd3);
        rd_chk("dvsr_3", 5'd1, 32'd3);
        wr(5'd2, 32'h0000_00A5);
        exp_idle(1);
        exp_frame(8'hA5, 3);
        repeat (3) @(negedge clk);
        rd_chk("busy_mid_frame", 5'd0, 32'h0000_0060);
        wait_drain("single_drain", 100);
        rd_chk("single_idle", 5'd0, 32'h0000_0020);

        // Back-to-back 0x00, 0xFF with DVSR=1
        wr(5'd1, 32'd1);
        wr(5'd2, 32'h0000_0000);
        exp_idle(1);
        exp_frame(8'h00, 1);
        wr(5'd2, 32'h0000_00FF);
        exp_frame(8'hFF, 1);
        exp_idle(3);
        rd_chk("b2b_status", 5'd0, 32'h0000_0041);
        wait_drain("b2b_drain", 100);
        rd_chk("b2b_idle", 5'd0, 32'h0000_0020);

        // Overflow with DVSR=100
        wr(5'd1, 32'd100);
        for (int i = 0; i < 10; i++) wr(5'd2, 32'h10 + i);
        rd_chk("ovf_status", 5'd0, 32'h0000_00D8);
        wr(5'd3, 32'h0);
        rd_chk("ovf_cleared", 5'd0, 32'h0000_0058);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ovf_reset_tx", {31'b0, tx}, 32'd1);
        rd_chk("ovf_reset_status", 5'd0, 32'h0000_0020);

        // DVSR change 3 -> 7 mid-frame
        wr(5'd1, 32'd3);
        wr(5'd2, 32'h0000_003C);
        exp_idle(1);
        exp_frame(8'h3C, 3);
        wr(5'd2, 32'h0000_0096);
        exp_frame(8'h96, 7);
        exp_idle(2);
        repeat (8) @(negedge clk);
        wr(5'd1, 32'd7);
        wait_drain("dvsr_change_drain", 200);
        rd_chk("dvsr_7", 5'd1, 32'd7);

        // Reset pulse during data bit 4
        wr(5'd1, 32'd3);
        wr(5'd2, 32'h0000_0055);
        exp_idle(1);
        repeat (4) exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) repeat (4) exp_q.push_back(i[0] ? 1'b0 : 1'b1);
        repeat (2) exp_q.push_back(1'b1);
        repeat (23) @(negedge clk);
        reset = 1'b1;
        exp_idle(40);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("midreset_status", 5'd0, 32'h0000_0020);
        wait_drain("midreset_drain", 100);
        rd_chk("midreset_status_end", 5'd0, 32'h0000_0020);
        rd_chk("midreset_dvsr", 5'd1, 32'd10415);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
